// File: rtl/csr_mtrap_pkg.sv
// Shared definitions for the machine-mode trap CSR block: CSR addresses,
// access encodings, mstatus/mie bit positions and the mtvec legalizer.
package csr_pkg;

    typedef enum logic [1:0] {
        READ_ONLY = 2'd0,
        WRITE     = 2'd1,
        SET       = 2'd2,
        CLEAR     = 2'd3
    } access_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK   = (32'd1 << MIE_MEIE) | (32'd1 << MIE_MTIE) | (32'd1 << MIE_MSIE);

    // Only direct (0) and vectored (1) modes exist; reserved modes collapse to direct.
    function automatic logic [31:0] mtvec_legalize(input logic [31:0] value);
        return {value[31:2], 1'b0, value[1] ? 1'b0 : value[0]};
    endfunction

endpackage

// File: rtl/csr_mtrap_if.sv
// CSR access port: address, access kind and operand in; read data and
// illegal-access flag back, both combinational.
interface csr_mtrap_if import csr_pkg::*;;
    logic [11:0] number;
    access_t     access_type;
    logic [31:0] in;
    logic [31:0] out;
    logic        illegal;

    modport master (output number, access_type, in, input out, illegal);
    modport slave  (input number, access_type, in, output out, illegal);
endinterface

// File: rtl/csr_mtrap_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves;
// a half write replaces the increment for that cycle and never carries.
module csr_counter64 #(
    parameter bit ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] count;

    always_ff @(posedge clk) begin
        if (reset || !ENABLE) begin
            count <= '0;
        end else if (wr_lo) begin
            count <= {count[63:32], wdata};
        end else if (wr_hi) begin
            count <= {wdata, count[31:0]};
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

    assign value = count;

endmodule

// File: rtl/csr_mtrap.sv
// Machine-mode trap CSR file: identification, status/interrupt enables,
// trap entry/return bookkeeping and the cycle/instret counters.
module csr_mtrap import csr_pkg::*; #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter int          COUNTERS_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    csr_mtrap_if.slave        csr,
    input  logic              trap_valid,
    input  logic [31:0]       trap_cause,
    input  logic [31:0]       trap_pc,
    input  logic [31:0]       trap_val,
    input  logic              mret,
    input  logic              retire,
    input  logic              irq_ext,
    input  logic              irq_timer,
    input  logic              irq_soft,
    output logic [31:0]       trap_vector,
    output logic [31:0]       epc,
    output logic              irq_pending
);

    logic        mstatus_mie, mstatus_mpie;
    logic [31:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0] mcycle, minstret, mcycle_rd, minstret_rd;
    logic [31:0] mstatus_rd, rdata, wdata, tvec_base;
    logic        implemented, wr_en;

    assign mcycle_rd   = (COUNTERS_EN != 0) ? mcycle   : '0;
    assign minstret_rd = (COUNTERS_EN != 0) ? minstret : '0;

    always_comb begin
        mstatus_rd = 32'h0000_1800;
        mstatus_rd[MSTATUS_MIE]  = mstatus_mie;
        mstatus_rd[MSTATUS_MPIE] = mstatus_mpie;
    end

    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (csr.number)
            CSR_MISA:                             rdata = MISA_VALUE;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
            CSR_MHARTID:                          rdata = HART_ID;
            CSR_MSTATUS:                          rdata = mstatus_rd;
            CSR_MIE:                              rdata = mie_q;
            CSR_MIP:                              rdata = mip_q;
            CSR_MTVEC:                            rdata = mtvec_q;
            CSR_MSCRATCH:                         rdata = mscratch_q;
            CSR_MEPC:                             rdata = mepc_q;
            CSR_MCAUSE:                           rdata = mcause_q;
            CSR_MTVAL:                            rdata = mtval_q;
            CSR_MCYCLE:                           rdata = mcycle_rd[31:0];
            CSR_MCYCLEH:                          rdata = mcycle_rd[63:32];
            CSR_MINSTRET:                         rdata = minstret_rd[31:0];
            CSR_MINSTRETH:                        rdata = minstret_rd[63:32];
            default:                              implemented = 1'b0;
        endcase
    end

    always_comb begin
        case (csr.access_type)
            WRITE:   wdata = csr.in;
            SET:     wdata = rdata | csr.in;
            CLEAR:   wdata = rdata & ~csr.in;
            default: wdata = rdata;
        endcase
    end

    assign csr.out     = rdata;
    assign csr.illegal = !implemented ||
                         (csr.number[11:10] == 2'b11 && csr.access_type != READ_ONLY);
    // Trap entry and mret both squash any CSR write issued alongside them.
    assign wr_en = (csr.access_type != READ_ONLY) && !csr.illegal && !trap_valid && !mret;

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mip_q        <= '0;
            mtvec_q      <= mtvec_legalize(MTVEC_RESET);
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
        end else begin
            mip_q <= {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
            if (trap_valid) begin
                mepc_q       <= {trap_pc[31:2], 2'b00};
                mcause_q     <= trap_cause;
                mtval_q      <= trap_val;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (wr_en) begin
                case (csr.number)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= wdata[MSTATUS_MIE];
                        mstatus_mpie <= wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= wdata & MIE_MASK;
                    CSR_MTVEC:    mtvec_q    <= mtvec_legalize(wdata);
                    CSR_MSCRATCH: mscratch_q <= wdata;
                    CSR_MEPC:     mepc_q     <= {wdata[31:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= wdata;
                    CSR_MTVAL:    mtval_q    <= wdata;
                    default:      ;
                endcase
            end
        end
    end

    csr_counter64 #(.ENABLE(COUNTERS_EN != 0)) u_mcycle (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .wr_lo (wr_en && csr.number == CSR_MCYCLE),
        .wr_hi (wr_en && csr.number == CSR_MCYCLEH),
        .wdata (wdata),
        .value (mcycle)
    );

    csr_counter64 #(.ENABLE(COUNTERS_EN != 0)) u_minstret (
        .clk   (clk),
        .reset (reset),
        .inc   (retire),
        .wr_lo (wr_en && csr.number == CSR_MINSTRET),
        .wr_hi (wr_en && csr.number == CSR_MINSTRETH),
        .wdata (wdata),
        .value (minstret)
    );

    // Vectored mode only redirects interrupts; exceptions always use the base.
    assign tvec_base   = {mtvec_q[31:2], 2'b00};
    assign trap_vector = (mtvec_q[1:0] == 2'b01 && trap_cause[31])
                       ? tvec_base + {25'b0, trap_cause[4:0], 2'b00}
                       : tvec_base;
    assign epc         = mepc_q;
    assign irq_pending = mstatus_mie && |(mie_q & mip_q);

endmodule

// File: tb/tb_csr_mtrap.sv
// Bench for csr_mtrap: directed scenarios plus random CSR/trap traffic, all
// outputs compared every cycle against an architectural model of the CSRs.
module tb_csr_mtrap;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        trap_valid, mret, retire, irq_ext, irq_timer, irq_soft, irq_pending;
    logic [31:0] trap_cause, trap_pc, trap_val, trap_vector, epc;

    csr_mtrap_if bus ();

    csr_mtrap #(
        .HART_ID     (32'd3),
        .MTVEC_RESET (32'h0000_1003),
        .COUNTERS_EN (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .csr         (bus),
        .trap_valid  (trap_valid),
        .trap_cause  (trap_cause),
        .trap_pc     (trap_pc),
        .trap_val    (trap_val),
        .mret        (mret),
        .retire      (retire),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .irq_soft    (irq_soft),
        .trap_vector (trap_vector),
        .epc         (epc),
        .irq_pending (irq_pending)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Architectural state of the model
    bit              m_mie, m_mpie;
    bit [31:0]       m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    longint unsigned m_cyc, m_ins;
    bit [2:0]        irq_lvl = 3'b000;

    function automatic void m_reset();
        m_mie = 0; m_mpie = 0; m_ie = 0; m_ip = 0;
        m_tvec = 32'h0000_1000;
        m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0;
        m_cyc = 0; m_ins = 0;
    endfunction

    function automatic void m_read(input bit [11:0] a, output bit [31:0] v, output bit ok);
        ok = 1; v = 0;
        case (a)
            12'h301: v = 32'h4000_0100;
            12'hF11, 12'hF12, 12'hF13: v = 0;
            12'hF14: v = 3;
            12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: v = m_ie;
            12'h344: v = m_ip;
            12'h305: v = m_tvec;
            12'h340: v = m_scratch;
            12'h341: v = m_epc;
            12'h342: v = m_cause;
            12'h343: v = m_tval;
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
            default: ok = 0;
        endcase
    endfunction

    function automatic void m_write(input bit [11:0] a, input bit [31:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h304: m_ie = v & 32'h0000_0888;
            12'h305: m_tvec = {v[31:2], 1'b0, v[1:0] == 2'd1};
            12'h340: m_scratch = v;
            12'h341: m_epc = v & ~32'h3;
            12'h342: m_cause = v;
            12'h343: m_tval = v;
            12'hB00: m_cyc = {m_cyc[63:32], v};
            12'hB80: m_cyc = {v, m_cyc[31:0]};
            12'hB02: m_ins = {m_ins[63:32], v};
            12'hB82: m_ins = {v, m_ins[31:0]};
            default: ;
        endcase
    endfunction

    // One clock: drive inputs after the falling edge, compare every output
    // against the model, then advance the model across the rising edge.
    task automatic cyc(input bit rst, input bit [11:0] num, input access_t acc, input bit [31:0] din,
                       input bit tv, input bit [31:0] tc, input bit [31:0] tp, input bit [31:0] tl,
                       input bit mr, input bit rt);
        bit [31:0] cur, wv, base, tvx;
        bit        ok, ill, wr, wc, wi;
        @(negedge clk);
        reset = rst; bus.number = num; bus.access_type = acc; bus.in = din;
        trap_valid = tv; trap_cause = tc; trap_pc = tp; trap_val = tl; mret = mr; retire = rt;
        {irq_ext, irq_timer, irq_soft} = irq_lvl;
        #1;
        m_read(num, cur, ok);
        ill  = !ok || (num[11:10] == 2'b11 && acc != READ_ONLY);
        base = m_tvec & ~32'h3;
        tvx  = (m_tvec[1:0] == 2'd1 && tc[31]) ? base + 32'(tc[4:0]) * 4 : base;
        check("out", bus.out, cur);
        check("illegal", 32'(bus.illegal), 32'(ill));
        check("trap_vector", trap_vector, tvx);
        check("epc", epc, m_epc);
        check("irq_pending", 32'(irq_pending), 32'(m_mie && ((m_ie & m_ip) != 0)));
        if (rst) begin
            m_reset();
        end else begin
            case (acc)
                WRITE:   wv = din;
                SET:     wv = cur | din;
                CLEAR:   wv = cur & ~din;
                default: wv = cur;
            endcase
            wr = acc != READ_ONLY && !ill && !tv && !mr;
            wc = wr && (num == 12'hB00 || num == 12'hB80);
            wi = wr && (num == 12'hB02 || num == 12'hB82);
            if (!wc) m_cyc++;
            if (!wi && rt) m_ins++;
            if (tv) begin
                m_epc = tp & ~32'h3; m_cause = tc; m_tval = tl;
                m_mpie = m_mie; m_mie = 0;
            end else if (mr) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (wr) begin
                m_write(num, wv);
            end
            m_ip = (32'(irq_lvl[2]) << 11) | (32'(irq_lvl[1]) << 7) | (32'(irq_lvl[0]) << 3);
        end
    endtask

    task automatic csr_op(input bit [11:0] num, input access_t acc, input bit [31:0] din);
        cyc(0, num, acc, din, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic trap(input bit [31:0] cause, input bit [31:0] pc);
        cyc(0, 12'h301, READ_ONLY, 0, 1, cause, pc, 32'hBAD0_0000 | pc, 0, 0);
    endtask

    bit [11:0] addrs [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11,
                              12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h123, 12'hB03};

    initial begin
        reset = 1; bus.number = 12'h301; bus.access_type = READ_ONLY; bus.in = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_val = 0; mret = 0; retire = 0;
        irq_ext = 0; irq_timer = 0; irq_soft = 0;
        repeat (3) @(posedge clk);
        m_reset();

        // Reset values and identification registers
        csr_op(12'h301, READ_ONLY, 0);
        check("rst_epc", epc, 32'h0);
        check("rst_irq_pending", 32'(irq_pending), 32'h0);
        check("rst_trap_vector", trap_vector, 32'h0000_1000);
        check("misa", bus.out, 32'h4000_0100);
        check("misa_illegal", 32'(bus.illegal), 32'h0);
        csr_op(12'hF14, READ_ONLY, 0);
        check("mhartid", bus.out, 32'd3);

        // mtvec WARL and vectored interrupt target
        csr_op(12'h305, WRITE, 32'h8000_0003);
        csr_op(12'h305, READ_ONLY, 0);
        check("mtvec_warl", bus.out, 32'h8000_0000);
        csr_op(12'h305, WRITE, 32'h8000_0001);
        trap(32'h8000_0007, 32'h0000_0400);
        check("vec_target", trap_vector, 32'h8000_001C);

        // Timer interrupt pending, trap entry, return
        csr_op(12'h300, WRITE, 32'h8);
        csr_op(12'h304, SET, 32'h80);
        irq_lvl = 3'b010;
        csr_op(12'h344, READ_ONLY, 0);
        csr_op(12'h344, READ_ONLY, 0);
        check("irq_pending_on", 32'(irq_pending), 32'h1);
        trap(32'h8000_0007, 32'h0000_0800);
        csr_op(12'h300, READ_ONLY, 0);
        check("trap_mstatus", bus.out, 32'h0000_1880);
        check("trap_irq_off", 32'(irq_pending), 32'h0);
        cyc(0, 12'h301, READ_ONLY, 0, 0, 0, 0, 0, 1, 0);
        csr_op(12'h300, READ_ONLY, 0);
        check("mret_mstatus", bus.out, 32'h0000_1888);
        irq_lvl = 3'b000;

        // Same-cycle trap, mret and mepc write: only the trap survives
        cyc(0, 12'h341, WRITE, 32'h1234, 1, 32'h2, 32'h5558, 32'h77, 1, 1);
        csr_op(12'h341, READ_ONLY, 0);
        check("prio_mepc", bus.out, 32'h0000_5558);
        csr_op(12'h300, READ_ONLY, 0);
        check("prio_mstatus", bus.out, 32'h0000_1880);

        // Counter half write, no carry from the write cycle, then wrap
        csr_op(12'hB80, WRITE, 32'h5);
        csr_op(12'hB00, WRITE, 32'hFFFF_FFFF);
        csr_op(12'hB80, READ_ONLY, 0);
        check("mcycleh_nocarry", bus.out, 32'h5);
        csr_op(12'hB00, READ_ONLY, 0);
        check("mcycle_rolled", bus.out, 32'h0);
        csr_op(12'hB80, READ_ONLY, 0);
        check("mcycleh_carry", bus.out, 32'h6);
        csr_op(12'hB80, WRITE, 32'hFFFF_FFFF);
        csr_op(12'hB00, WRITE, 32'hFFFF_FFFF);
        csr_op(12'hB00, READ_ONLY, 0);
        csr_op(12'hB80, READ_ONLY, 0);
        check("mcycle_wrap", bus.out, 32'h0);

        // Illegal accesses leave state alone
        csr_op(12'h340, WRITE, 32'hAAAA_5555);
        csr_op(12'hF11, WRITE, 32'h1);
        check("wr_mvendorid", 32'(bus.illegal), 32'h1);
        csr_op(12'h7C0, SET, 32'hFFFF_FFFF);
        check("wr_unimpl", 32'(bus.illegal), 32'h1);
        csr_op(12'hF11, READ_ONLY, 0);
        check("rd_mvendorid", 32'(bus.illegal), 32'h0);
        csr_op(12'h340, READ_ONLY, 0);
        check("mscratch_kept", bus.out, 32'hAAAA_5555);

        // Reset beats a same-cycle trap and write
        cyc(1, 12'h340, WRITE, 32'h1, 1, 32'h3, 32'h100, 32'h5, 0, 1);
        csr_op(12'h340, READ_ONLY, 0);
        check("rst_override", bus.out, 32'h0);
        check("rst_override_epc", epc, 32'h0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit [11:0] a;
            bit rst, tv, mr;
            a   = addrs[$urandom_range(0, 19)];
            rst = ($urandom_range(0, 99) == 0);
            tv  = ($urandom_range(0, 9) == 0);
            mr  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) irq_lvl = 3'($urandom_range(0, 7));
            cyc(rst, a, access_t'($urandom_range(0, 3)), $urandom, tv, $urandom, $urandom, $urandom,
                mr, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
